// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU memory-port arbiter: owner codes, FSM states
// and the IE-vs-IF arbitration decision.
package ie_defs;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_IE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  // IE normally wins; a full streak with IF waiting hands the port to IF.
  function automatic logic ie_wins(input logic ie_req, input logic if_req,
                                   input logic streak_full);
    return ie_req && !(if_req && streak_full);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Two-requester arbiter for the CPU's single 8-bit/16-bit memory port.
// IE has priority, bounded by a streak limiter so IF always progresses.
module cpu_mem_arbiter
  import ie_defs::*;
#(
  parameter int MEM_LAT       = 1,
  parameter int MAX_IE_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [7:0]  if_rdata,
  input  logic        ie_req,
  input  logic        ie_we,
  input  logic [15:0] ie_addr,
  input  logic [7:0]  ie_wdata,
  output logic        ie_ack,
  output logic [7:0]  ie_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [1:0]  owner
);

  arb_state_t  state;
  arb_state_t  state_next;
  logic        grant_if;
  logic        grant_ie;
  logic [3:0]  streak;
  logic        streak_full;
  logic [1:0]  lat_cnt;
  logic [15:0] addr_lat;
  logic [7:0]  wdata_lat;
  logic        we_lat;

  assign streak_full = (streak == 4'(MAX_IE_STREAK));

  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_ie   = 1'b0;
    case (state)
      IDLE: begin
        if (ie_wins(ie_req, if_req, streak_full)) begin
          grant_ie   = 1'b1;
          state_next = ISSUE;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = we_lat ? ACK : WAIT;
      WAIT:    if (lat_cnt == 2'(MEM_LAT - 1)) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_lat  <= 16'h0000;
      wdata_lat <= 8'h00;
      we_lat    <= 1'b0;
      owner     <= OWN_NONE;
      busy      <= 1'b0;
      streak    <= 4'd0;
      lat_cnt   <= 2'd0;
    end else begin
      if (grant_ie) begin
        addr_lat  <= ie_addr;
        wdata_lat <= ie_wdata;
        we_lat    <= ie_we;
        owner     <= OWN_IE;
      end else if (grant_if) begin
        addr_lat  <= if_addr;
        wdata_lat <= 8'h00;
        we_lat    <= 1'b0;
        owner     <= OWN_IF;
      end else if (state_next == IDLE) begin
        owner <= OWN_NONE;
      end
      busy <= (state_next != IDLE);
      // Only IE grants made while IF is actually waiting extend the streak.
      if (grant_if) begin
        streak <= 4'd0;
      end else if (grant_ie) begin
        if (!if_req)          streak <= 4'd0;
        else if (!streak_full) streak <= streak + 4'd1;
      end
      lat_cnt <= (state == WAIT) ? lat_cnt + 2'd1 : 2'd0;
    end
  end

  // Outputs trail the state by one cycle; the memory read data therefore
  // lands MEM_LAT cycles after the strobe, which is the edge that leaves ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      if_ack    <= 1'b0;
      ie_ack    <= 1'b0;
      if_rdata  <= 8'h00;
      ie_rdata  <= 8'h00;
    end else begin
      mem_re <= (state == ISSUE) && !we_lat;
      mem_we <= (state == ISSUE) && we_lat;
      if (state == ISSUE) begin
        mem_addr  <= addr_lat;
        mem_wdata <= wdata_lat;
      end
      if_ack <= (state == ACK) && (owner == OWN_IF);
      ie_ack <= (state == ACK) && (owner == OWN_IE);
      if (state == ACK && !we_lat) begin
        if (owner == OWN_IF)      if_rdata <= mem_rdata;
        else if (owner == OWN_IE) ie_rdata <= mem_rdata;
      end
    end
  end

endmodule
